// File: rtl/regfile_alu_wb_if.sv
// rtl/regfile_alu_wb_if.sv - issue handshake and 3-port regfile bus for regfile_alu_wb
interface regfile_alu_wb_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [AW-1:0]    in_rs1;
    logic [AW-1:0]    in_rs2;
    logic [AW-1:0]    in_rd;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic             done;
    logic             ovf;

    // master: the sequencer; slave: issue source plus register file
    modport master (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, rd1, rd2,
        output in_ready, ra1, ra2, we3, wa3, wd3, done, ovf
    );

    modport slave (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, rd1, rd2,
        input  in_ready, ra1, ra2, we3, wa3, wd3, done, ovf
    );
endinterface

// File: rtl/regfile_alu_wb.sv
// rtl/regfile_alu_wb.sv - four-state read/execute/writeback sequencer around a 3-port regfile
module regfile_alu_wb #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    regfile_alu_wb_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    state_t           state;
    state_t           state_nx;
    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    ra1_q;
    logic [AW-1:0]    ra2_q;
    logic [AW-1:0]    wa3_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] wd3_q;
    logic             ovf_q;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign accept = (state == IDLE) && bus.in_valid;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = READ;
            READ:    state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL:  alu_res = a_q << b_q[4:0];
            OP_SRL:  alu_res = a_q >> b_q[4:0];
            default: alu_res = '0;
        endcase
    end

    // Read/write address and data registers only load on entry to READ / WB, so they hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            op_q  <= '0;
            rd_q  <= '0;
            ra1_q <= '0;
            ra2_q <= '0;
            wa3_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            wd3_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= bus.in_op;
                rd_q  <= bus.in_rd;
                ra1_q <= bus.in_rs1;
                ra2_q <= bus.in_rs2;
            end
            if (state == READ) begin
                a_q <= bus.rd1;
                b_q <= bus.rd2;
            end
            if (state == EXEC) begin
                wd3_q <= alu_res;
                wa3_q <= rd_q;
                ovf_q <= alu_ovf;
            end
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.ra1      = ra1_q;
    assign bus.ra2      = ra2_q;
    assign bus.wa3      = wa3_q;
    assign bus.wd3      = wd3_q;
    assign bus.done     = (state == WB);
    assign bus.we3      = (state == WB) && (rd_q != '0);
    assign bus.ovf      = (state == WB) && ovf_q;

endmodule

// File: tb/tb_regfile_alu_wb.sv
// tb/tb_regfile_alu_wb.sv - randomized and directed bench for regfile_alu_wb with a behavioural regfile
module tb_regfile_alu_wb;

    logic clk;
    logic reset_n;

    regfile_alu_wb_if #(.WIDTH(32), .AW(5)) bus ();

    regfile_alu_wb #(.WIDTH(32), .AW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf [32];
    logic [31:0] model_rf [32];
    logic        pl_en;
    logic [4:0]  pl_a;
    logic [31:0] pl_d;
    int          wr_count;
    int          passed;
    int          total;

    assign bus.rd1 = rf[bus.ra1];
    assign bus.rd2 = rf[bus.ra2];

    always @(posedge clk) begin
        if (pl_en) rf[pl_a] <= pl_d;
        else if (bus.we3) rf[bus.wa3] <= bus.wd3;
    end

    initial wr_count = 0;
    always @(posedge clk) if (bus.we3) wr_count <= wr_count + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
        longint sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        o  = 1'b0;
        case (op)
            3'd0: s = sa + sb;
            3'd1: s = sa - sb;
            default: s = 0;
        endcase
        case (op)
            3'd0, 3'd1: begin
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = a << (b % 32);
            default: r = a >> (b % 32);
        endcase
    endfunction

    task automatic preload(input int a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = a[4:0];
        pl_d  = d;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
        model_rf[a] = d;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Caller is at a negedge; returns at the negedge of the IDLE cycle after WB
    task automatic run_op(input logic [2:0] op, input int rs1, input int rs2, input int rd);
        logic [31:0] exp_r;
        logic        exp_o;
        int          wc;
        model(op, model_rf[rs1], model_rf[rs2], exp_r, exp_o);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = rs1[4:0];
        bus.in_rs2   = rs2[4:0];
        bus.in_rd    = rd[4:0];
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_rd    = 5'($urandom);
        check("read_ra1", {27'd0, bus.ra1}, rs1);
        check("read_ra2", {27'd0, bus.ra2}, rs2);
        check("read_busy", {30'd0, bus.in_ready, bus.done}, 32'd0);
        @(negedge clk);
        check("exec_quiet", {30'd0, bus.we3, bus.done}, 32'd0);
        @(negedge clk);
        wc = wr_count;
        check("wb_done", {31'd0, bus.done}, 32'd1);
        check("wb_we3", {31'd0, bus.we3}, (rd != 0) ? 32'd1 : 32'd0);
        check("wb_wa3", {27'd0, bus.wa3}, rd);
        check("wb_wd3", bus.wd3, exp_r);
        check("wb_ovf", {31'd0, bus.ovf}, {31'd0, exp_o});
        @(negedge clk);
        if (rd != 0) model_rf[rd] = exp_r;
        check("idle_ready", {31'd0, bus.in_ready}, 32'd1);
        check("idle_done", {31'd0, bus.done}, 32'd0);
        check("write_count", wr_count - wc, (rd != 0) ? 32'd1 : 32'd0);
        check("rf_after_wb", rf[rd], model_rf[rd]);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_we3_done_ovf"}, {29'd0, bus.we3, bus.done, bus.ovf}, 32'd0);
        check({tag, "_addr"}, {17'd0, bus.ra1, bus.ra2, bus.wa3}, 32'd0);
        check({tag, "_wd3"}, bus.wd3, 32'd0);
    endtask

    initial begin
        int wc;
        passed       = 0;
        total        = 0;
        pl_en        = 1'b0;
        pl_a         = '0;
        pl_d         = '0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.in_rd    = '0;
        reset_n      = 1'b0;
        repeat (4) @(negedge clk);
        reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 32; i++) preload(i, (i == 0) ? 32'd0 : $urandom);

        preload(1, 32'd6);
        preload(2, 32'd7);
        run_op(3'd0, 1, 2, 3);

        preload(1, 32'h7FFF_FFFF);
        preload(2, 32'd1);
        run_op(3'd0, 1, 2, 6);
        preload(1, 32'h8000_0000);
        run_op(3'd1, 1, 2, 7);

        preload(1, 32'hFFFF_FFFF);
        run_op(3'd5, 1, 2, 8);
        preload(1, 32'h8000_0000);
        preload(2, 32'd4);
        run_op(3'd7, 1, 2, 10);
        preload(1, 32'd3);
        preload(2, 32'h21);
        run_op(3'd6, 1, 2, 11);

        preload(1, 32'd3);
        preload(2, 32'd5);
        run_op(3'd0, 1, 2, 0);
        check("r0_zero", rf[0], 32'd0);
        run_op(3'd3, 0, 2, 12);

        // Abort in EXEC: the pending write to r5 must never land
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd0;
        bus.in_rs1   = 5'd1;
        bus.in_rs2   = 5'd2;
        bus.in_rd    = 5'd5;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        wc = wr_count;
        reset_n = 1'b0;
        #1;
        reset_outputs("abort_exec");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_exec_writes", wr_count - wc, 32'd0);
        check("abort_exec_r5", rf[5], model_rf[5]);

        // Abort in WB, before the writing edge
        bus.in_valid = 1'b1;
        bus.in_rd    = 5'd5;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_wb_we3", {31'd0, bus.we3}, 32'd1);
        wc = wr_count;
        reset_n = 1'b0;
        #1;
        check("abort_wb_we3", {31'd0, bus.we3}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_wb_writes", wr_count - wc, 32'd0);
        check("abort_wb_r5", rf[5], model_rf[5]);

        run_op(3'd4, 1, 2, 5);
        run_op(3'd0, 1, 2, 3);
        run_op(3'd0, 3, 3, 4);

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_alu_wb.md
# regfile_alu_wb

Multi-cycle operate-and-writeback sequencer that drives a 3-port register file (two combinational read ports, one clocked write port). It accepts one register-register operation at a time from an upstream issue source. It reads both source operands through the regfile read ports, computes an ALU result, and writes it back through the regfile write port. Register 0 is treated as the hardwired-zero block: writebacks to address 0 are suppressed.

## Interface
Parameters:
- WIDTH, 32, data width of operands, result, wd3, rd1 and rd2
- AW, 5, register address width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  block can accept an operation (high only in IDLE)
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL
- in_rs1, in_rs2  in  AW  source register addresses
- in_rd  in  AW  destination register address
- ra1, ra2  out  AW  regfile read addresses
- rd1, rd2  in  WIDTH  regfile read data, combinational from ra1/ra2
- we3  out  1  regfile write enable
- wa3  out  AW  regfile write address
- wd3  out  WIDTH  regfile write data
- done  out  1  one-cycle pulse in the WB cycle
- ovf  out  1  signed overflow of ADD/SUB, valid while done=1, 0 for other ops

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE:
  - in_ready=1.
  - If in_valid is high at a rising edge, latch op, rs1, rs2 and rd, then go to READ.
  - Otherwise stay in IDLE.
- READ:
  - ra1 = latched rs1, ra2 = latched rs2.
  - At the end of the cycle, capture rd1/rd2 into operand registers A/B.
  - Go to EXEC.
- EXEC:
  - Compute on A/B and register the result and ovf.
  - Go to WB.
- WB:
  - wa3 = latched rd, wd3 = result, done=1.
  - we3=1 unless rd==0, in which case we3=0 and done is still 1.
  - Go to IDLE.
- Arithmetic rules:
  - ADD/SUB: modulo 2^WIDTH.
  - ovf: set when the operand signs match (ADD) or differ (SUB) and the result sign differs from A.
  - SLT: result is 1 if $signed(A) < $signed(B), else 0.
  - SLL/SRL: shift amount is B[4:0]; SRL is a logical shift (zero fill).
- ra1/ra2 hold their last value outside READ. wa3/wd3 hold their last value outside WB. we3 is 0 outside WB.
- in_valid while not in IDLE is ignored; the upstream must hold the operation until it sees in_ready.
- Read-after-write is safe across back-to-back operations: the next READ begins at least one cycle after the WB edge has committed the write.

## Timing
- Reset (async assert, reset_n=0):
  - State goes to IDLE.
  - we3=0, done=0, ovf=0.
  - ra1=ra2=wa3=0, wd3=0.
  - in_ready=1 once reset is released.
- Reset asserted mid-operation aborts immediately; no regfile write occurs, even if asserted during WB before the edge.
- Latency: accept at edge T; READ during T..T+1; EXEC during T+1..T+2; WB during T+2..T+3 (write lands at edge T+3). IDLE and in_ready=1 in cycle T+3..T+4.
- Throughput: one operation per 4 cycles.
- in_ready is a Moore output (decoded from state). done and we3 are also decoded from state and qualified by the latched rd.

## Test plan
- Reset, then hold reset_n=0 over several clocks -> in_ready=1, we3=0, done=0, ra1=ra2=wa3=0, wd3=0.
- Preload r1=6, r2=7. Issue ADD rd=3, rs1=1, rs2=2 -> ra1=1/ra2=2 in READ. WB cycle has we3=1, wa3=3, wd3=13, done=1, ovf=0. in_ready returns 3 cycles after accept.
- Preload r1=0x7FFFFFFF, r2=1. Issue ADD -> wd3=0x80000000, ovf=1. Then issue SUB with r1=0x80000000, r2=1 -> wd3=0x7FFFFFFF, ovf=1.
- Issue SLT with A=0xFFFFFFFF, B=1 -> wd3=1. Issue SRL with A=0x80000000, B=4 -> wd3=0x08000000. Issue SLL with B=0x21 (amount 1) on A=3 -> wd3=6.
- Issue an operation with rd=0 and result 8 -> done=1, we3=0. A subsequent read of r0 through ra1 returns 0.
- Drop reset_n during EXEC of an ADD to r5 -> no we3 pulse and r5 unchanged. After release, in_ready=1 and a new operation completes normally. Issue a back-to-back ADD r4=r3+r3 after r3 was written -> uses the new r3 value.
